demux1to11_loader: RTL
======================

Name: demux1to11_loader

Overview:
- Write-side counterpart of the 11-way byte selector: scatters one incoming byte stream into 11 registered byte outputs, OUT0..OUT10.
- Feeds the selector's IN0..IN10 bank, e.g. round-key or operand bytes for the encrypt datapath.
- Two modes. Addressed single-byte write via SEL. Burst load of all 11 registers in index order over a VALID/READY handshake.
- Per-register written flags and a completion pulse let downstream logic know when the bank is complete.

Parameters:
- WIDTH, 8, byte width of IN and each OUTn. The register count is fixed at 11; indices 0..10 only.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  synchronous, active-high reset.
- IN  input  WIDTH  data byte for both modes.
- SEL  input  4  target index for an addressed write; legal values 0..10.
- WR  input  1  addressed-write strobe; sampled every cycle.
- START  input  1  begins a burst load at index 0.
- IN_VALID  input  1  burst byte present on IN.
- IN_READY  output  1  block accepts a burst byte this cycle.
- OUT0..OUT10  output  WIDTH each  registered byte bank.
- WRITTEN  output  11  bit n set once OUTn has been written since the last RST or START.
- BUSY  output  1  high in LOAD state.
- DONE  output  1  one-cycle pulse after the 11th burst byte is accepted.
- ERR  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset: when RST is high at a CLK edge, all OUTn <= 0, WRITTEN <= 0, state <= IDLE, index <= 0, DONE/ERR <= 0. RST overrides all other inputs, including mid-burst.
- States: IDLE, LOAD, FIN.
- IN_READY = (state == LOAD). It is combinational from state only and never depends on IN_VALID.
- BUSY = (state == LOAD).

IDLE:
- START=1: WRITTEN <= 0, index <= 0, next state LOAD. START wins over WR; a simultaneous WR is dropped with no ERR.
- WR=1 and SEL<=10: OUT[SEL] <= IN and WRITTEN[SEL] <= 1. The new value is visible the cycle after the edge (1-cycle latency).
- WR=1 and SEL>=11: no register changes; ERR pulses high for one cycle.

LOAD:
- Each cycle with IN_VALID=1 (IN_READY is 1): OUT[index] <= IN, WRITTEN[index] <= 1, index <= index+1.
- IN_VALID=0 is a stall: nothing changes. There is no timeout.
- Accepting the byte at index 10: index wraps to 0 and next state is FIN.
- WR in LOAD: ignored; ERR pulses, no write.
- START in LOAD: ignored; no restart, no ERR.

FIN:
- Lasts exactly one cycle. DONE=1, IN_READY=0, WR and START ignored with no ERR. Next state IDLE.

Timing and arithmetic:
- DONE and ERR are registered pulses, high the cycle after the triggering edge.
- Back-to-back bursts: START in the IDLE cycle right after FIN is honoured. Minimum burst period is 13 cycles: 1 START + 11 bytes + 1 FIN.
- index is 4 bits and never exceeds 10. Bytes pass through unmodified; no arithmetic on data.
- OUTn hold their values indefinitely; only a write or RST changes them.

Decomposition:
- Shared package holds:
  - NUM_REGS = 11 and MAX_SEL = 4'd10.
  - State encodings IDLE=2'd0, LOAD=2'd1, FIN=2'd2; the unused code 2'd3 recovers to IDLE.
- One natural sub-module: demux_decode4to11. It decodes a 4-bit index plus an enable into an 11-bit one-hot write-enable with an out-of-range flag.
  - The top instance muxes SEL or index into it depending on state.
  - The register bank and FSM stay in the top.

Test Plan:
- Reset: preload bank via bursts, assert RST for 1 cycle mid-LOAD at index 5 -> next cycle all OUTn=0x00, WRITTEN=0, BUSY=0, IN_READY=0.
- Addressed write: WR=1, SEL=3, IN=0xA5 -> OUT3=0xA5 next cycle, WRITTEN=11'h008, all other OUTn unchanged. Then SEL=11, IN=0xFF -> ERR pulse, no OUTn change.
- Full burst: START, then IN_VALID=1 for 11 cycles with IN=0x10..0x1A -> OUTn=0x10+n, WRITTEN=11'h7FF, DONE high exactly one cycle after the 11th accept, BUSY low after FIN.
- Stalls: burst with IN_VALID toggling 1,0,0,1,... -> only valid cycles written, correct order, and DONE after exactly 11 accepts regardless of the gaps.
- Collisions:
  - WR during LOAD at index 4 -> ERR pulse, burst order unaffected.
  - START during LOAD -> ignored, index continues.
  - START+WR together in IDLE -> burst starts, addressed write dropped, no ERR.
- Back-to-back: START in the first IDLE cycle after FIN with new data 0x20..0x2A -> WRITTEN clears then refills, all OUTn updated, second DONE 13 cycles after the first.

Source files
------------

// File: rtl/demux1to11_loader_pkg.sv
// Shared definitions for the 1-to-11 byte loader: register count,
// highest legal index, FSM encoding and a debug snapshot type.
package demux1to11_loader_pkg;

  localparam int         NUM_REGS = 11;
  localparam logic [3:0] MAX_SEL  = 4'd10;

  // Code 2'd3 is unused and steers back to IDLE in the next-state logic.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Snapshot of the control path, kept as one signal so checkers can bind to it.
  typedef struct packed {
    state_t     state;
    logic [3:0] index;
  } loader_dbg_t;

  // True when an index addresses one of the eleven registers.
  function automatic logic idx_legal(input logic [3:0] idx);
    return idx <= MAX_SEL;
  endfunction

endpackage

// File: rtl/demux_decode4to11.sv
// Decodes a 4-bit index plus enable into an 11-bit one-hot write enable.
// Indices 11..15 produce no enable and raise out_of_range instead.
module demux_decode4to11
  import demux1to11_loader_pkg::*;
(
  input  logic [3:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot,
  output logic                out_of_range
);

  // One-hot decode, gated by the enable and the legal index range.
  always_comb begin
    onehot       = '0;
    out_of_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (idx == 4'(i));
    end
    out_of_range = en && !idx_legal(idx);
  end

endmodule

// File: rtl/demux1to11_loader.sv
// Scatters a byte stream into eleven registered byte outputs, either one
// addressed byte at a time (SEL/WR) or as an in-order burst (START then
// IN_VALID/IN_READY). Tracks which registers were written and pulses DONE
// when a burst completes and ERR on an illegal request.
//
// Burst handshake: a byte transfers on every rising edge where
// IN_VALID && IN_READY. IN_READY depends only on state (high in LOAD);
// the source may hold IN_VALID low for any number of cycles to stall.
module demux1to11_loader
  import demux1to11_loader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [WIDTH-1:0]    IN,
  input  logic [3:0]          SEL,
  input  logic                WR,
  input  logic                START,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [WIDTH-1:0]    OUT0,
  output logic [WIDTH-1:0]    OUT1,
  output logic [WIDTH-1:0]    OUT2,
  output logic [WIDTH-1:0]    OUT3,
  output logic [WIDTH-1:0]    OUT4,
  output logic [WIDTH-1:0]    OUT5,
  output logic [WIDTH-1:0]    OUT6,
  output logic [WIDTH-1:0]    OUT7,
  output logic [WIDTH-1:0]    OUT8,
  output logic [WIDTH-1:0]    OUT9,
  output logic [WIDTH-1:0]    OUT10,
  output logic [NUM_REGS-1:0] WRITTEN,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  state_t              state_q, state_d;
  logic [3:0]          index_q, index_d;
  logic [NUM_REGS-1:0] written_q, written_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    bank_q [NUM_REGS];

  logic [3:0]          dec_idx;
  logic                dec_en;
  logic [NUM_REGS-1:0] wr_en;
  logic                dec_oor;

  loader_dbg_t         dbg;

  assign dbg = '{state: state_q, index: index_q};

  // Decoder source: the burst index while loading, otherwise the addressed
  // write. START in IDLE suppresses the addressed write entirely.
  always_comb begin
    dec_idx = SEL;
    dec_en  = 1'b0;
    if (state_q == LOAD) begin
      dec_idx = index_q;
      dec_en  = IN_VALID;
    end else if (state_q == IDLE) begin
      dec_idx = SEL;
      dec_en  = WR && !START;
    end
  end

  demux_decode4to11 u_decode (
    .idx          (dec_idx),
    .en           (dec_en),
    .onehot       (wr_en),
    .out_of_range (dec_oor)
  );

  // Next-state, burst index, written flags and pulse requests.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    written_d = written_q | wr_en;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = LOAD;
          index_d   = 4'd0;
          written_d = '0;
        end else begin
          err_d = dec_oor;
        end
      end
      LOAD: begin
        // Any addressed write during a burst is refused; START is ignored.
        err_d = WR;
        if (IN_VALID) begin
          if (index_q == MAX_SEL) begin
            index_d = 4'd0;
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 4'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        index_d = 4'd0;
      end
    endcase
  end

  // Control registers: state, index, written flags and the two pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      index_q   <= 4'd0;
      written_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      written_q <= written_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Byte bank: each register loads IN when its one-hot enable is set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) begin
          bank_q[i] <= IN;
        end
      end
    end
  end

  assign IN_READY = (state_q == LOAD);
  assign BUSY     = (state_q == LOAD);
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign WRITTEN  = written_q;

  assign OUT0  = bank_q[0];
  assign OUT1  = bank_q[1];
  assign OUT2  = bank_q[2];
  assign OUT3  = bank_q[3];
  assign OUT4  = bank_q[4];
  assign OUT5  = bank_q[5];
  assign OUT6  = bank_q[6];
  assign OUT7  = bank_q[7];
  assign OUT8  = bank_q[8];
  assign OUT9  = bank_q[9];
  assign OUT10 = bank_q[10];

endmodule
